// File: rtl/i_mem_pipe.sv
// i_mem_pipe: loader-written instruction memory with a LATENCY-stage fetch pipeline and a 2-entry response FIFO.
// Optional feature macro I_MEM_PARITY_EN: one even-parity bit per word, checked on every fetch.
module i_mem_pipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [31:0]       ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CAP   = LATENCY + 1;
  localparam int unsigned OCC_W = $clog2(CAP + 1);
  localparam int unsigned NS    = (LATENCY > 1) ? LATENCY - 1 : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  ld_idx;
  logic              req_bad;
  logic              ld_ok;
  logic              accept;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] in_data;
  logic              in_err;

  logic              push_v;
  logic              push_e;
  logic [DATA_W-1:0] push_d;
  logic              can_push;
  logic              pop;

  // Request / loader address decode; faulting fetches never touch the array.
  assign accept  = req_valid & req_ready;
  assign req_idx = req_addr[IDX_W+1:2];
  assign ld_idx  = ld_addr[IDX_W+1:2];
  assign req_bad = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));
  assign ld_ok   = (ld_addr[1:0] == 2'b00) && (ld_addr[31:2] < 30'(DEPTH));
  assign rd_word = req_bad ? '0 : mem[req_idx];
  assign in_data = rd_word;

`ifdef I_MEM_PARITY_EN
  logic par_mem [DEPTH];
  logic par_bad;

  always_ff @(posedge clk) begin
    if (ld_en && ld_ok) begin
      mem[ld_idx]     <= ld_data;
      par_mem[ld_idx] <= ^ld_data;
    end
  end

  // Read sees the pre-write word, so a same-cycle load cannot cause a false parity hit.
  assign par_bad = !req_bad && ((^rd_word) != par_mem[req_idx]);
  assign in_err  = req_bad | par_bad;
`else
  always_ff @(posedge clk) begin
    if (ld_en && ld_ok) begin
      mem[ld_idx] <= ld_data;
    end
  end

  assign in_err = req_bad;
`endif

  generate
    if (LATENCY > 1) begin : g_pipe
      logic              sv [NS];
      logic              se [NS];
      logic [DATA_W-1:0] sd [NS];
      logic              nv [NS];
      logic              ne [NS];
      logic [DATA_W-1:0] nd [NS];
      logic [NS-1:0]     en;

      // Stage inputs and load enables; a stage may load when any slot downstream frees up.
      always_comb begin
        logic bubble;
        nv[0]  = accept;
        ne[0]  = in_err;
        nd[0]  = in_data;
        for (int i = 1; i < int'(NS); i++) begin
          nv[i] = sv[i-1];
          ne[i] = se[i-1];
          nd[i] = sd[i-1];
        end
        en     = '0;
        bubble = can_push;
        for (int i = int'(NS) - 1; i >= 0; i--) begin
          bubble = bubble | !sv[i];
          en[i]  = bubble;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < int'(NS); i++) begin
            sv[i] <= 1'b0;
            se[i] <= 1'b0;
            sd[i] <= '0;
          end
        end else begin
          for (int i = 0; i < int'(NS); i++) begin
            if (en[i]) begin
              sv[i] <= nv[i];
              se[i] <= ne[i];
              sd[i] <= nd[i];
            end
          end
        end
      end

      assign push_v = sv[NS-1] & can_push;
      assign push_e = se[NS-1];
      assign push_d = sd[NS-1];
    end else begin : g_direct
      assign push_v = accept;
      assign push_e = in_err;
      assign push_d = in_data;
    end
  endgenerate

  // Two-entry response FIFO as head + tail registers so outputs come straight from flops.
  logic              h_v;
  logic              h_e;
  logic [DATA_W-1:0] h_d;
  logic              t_v;
  logic              t_e;
  logic [DATA_W-1:0] t_d;

  assign pop      = h_v & rsp_ready;
  assign can_push = !t_v || pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_v <= 1'b0;
      h_e <= 1'b0;
      h_d <= '0;
      t_v <= 1'b0;
      t_e <= 1'b0;
      t_d <= '0;
    end else if (pop) begin
      if (t_v) begin
        h_v <= 1'b1;
        h_e <= t_e;
        h_d <= t_d;
        t_v <= push_v;
        if (push_v) begin
          t_e <= push_e;
          t_d <= push_d;
        end
      end else begin
        h_v <= push_v;
        if (push_v) begin
          h_e <= push_e;
          h_d <= push_d;
        end
      end
    end else if (push_v) begin
      if (!h_v) begin
        h_v <= 1'b1;
        h_e <= push_e;
        h_d <= push_d;
      end else begin
        t_v <= 1'b1;
        t_e <= push_e;
        t_d <= push_d;
      end
    end
  end

  assign rsp_valid = h_v;
  assign rsp_err   = h_e;
  assign rsp_data  = h_d;

  // Credit: accepted-but-not-popped entries never exceed pipeline slots plus FIFO depth.
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_nxt;

  assign occ_nxt = occ + OCC_W'(accept) - OCC_W'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= '0;
      req_ready <= 1'b0;
    end else begin
      occ       <= occ_nxt;
      req_ready <= (occ_nxt < OCC_W'(CAP));
    end
  end

endmodule

// File: tb/tb_i_mem_pipe.sv
// Directed self-checking bench for i_mem_pipe (DEPTH=128, LATENCY=2).
// Parity-fault case runs only when I_MEM_PARITY_EN is defined.
module tb_i_mem_pipe;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DEPTH   = 128;
  localparam int unsigned LATENCY = 2;

  localparam logic [31:0] W0 = 32'h20080005;
  localparam logic [31:0] W1 = 32'h20090007;
  localparam logic [31:0] W2 = 32'h01095020;
  localparam logic [31:0] W3 = 32'hAC0A0000;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              ld_en;
  logic [31:0]       ld_addr;
  logic [DATA_W-1:0] ld_data;

  int checks = 0;
  int errors = 0;

  i_mem_pipe #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] addr);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_addr  = addr;
    while (req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("issue_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [31:0] exp_d, input logic exp_e);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_data"}, rsp_data, exp_d);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;

    // Reset state.
    tick();
    tick();
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_valid", 32'(rsp_valid), 32'd0);

    // Load words 0..3.
    ld_en = 1'b1;
    ld_addr = 32'h0; ld_data = W0; tick();
    ld_addr = 32'h4; ld_data = W1; tick();
    ld_addr = 32'h8; ld_data = W2; tick();
    ld_addr = 32'hC; ld_data = W3; tick();
    ld_en = 1'b0;

    // Back-to-back reads: first response two cycles after first accept, then one per cycle.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    chk("b2b_ready0", 32'(req_ready), 32'd1);
    tick();
    chk("b2b_lat_valid", 32'(rsp_valid), 32'd0);
    chk("b2b_ready1", 32'(req_ready), 32'd1);
    req_addr = 32'h4;
    tick();
    chk("b2b_v0", 32'(rsp_valid), 32'd1);
    chk("b2b_d0", rsp_data, W0);
    chk("b2b_ready2", 32'(req_ready), 32'd1);
    req_addr = 32'h8;
    tick();
    chk("b2b_v1", 32'(rsp_valid), 32'd1);
    chk("b2b_d1", rsp_data, W1);
    chk("b2b_ready3", 32'(req_ready), 32'd1);
    req_addr = 32'hC;
    tick();
    chk("b2b_v2", 32'(rsp_valid), 32'd1);
    chk("b2b_d2", rsp_data, W2);
    req_valid = 1'b0;
    tick();
    chk("b2b_v3", 32'(rsp_valid), 32'd1);
    chk("b2b_d3", rsp_data, W3);
    chk("b2b_e3", 32'(rsp_err), 32'd0);
    tick();
    chk("b2b_drain", 32'(rsp_valid), 32'd0);

    // Consumer stall: only LATENCY+1 requests may be accepted.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    acc = 0;
    req_addr = 32'h0;
    for (int c = 0; c < 10; c++) begin
      if (req_ready === 1'b1) acc++;
      tick();
      req_addr = 32'(acc * 4);
    end
    req_valid = 1'b0;
    chk("stall_accepts", 32'(acc), 32'd3);
    chk("stall_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    collect("stall_r0", W0, 1'b0);
    collect("stall_r1", W1, 1'b0);
    collect("stall_r2", W2, 1'b0);
    tick();
    chk("stall_empty", 32'(rsp_valid), 32'd0);
    chk("stall_ready_back", 32'(req_ready), 32'd1);

    // Fetch faults: misaligned and out-of-range, then a clean fetch.
    rsp_ready = 1'b0;
    issue(32'h6);
    issue(32'h200);
    issue(32'h0);
    rsp_ready = 1'b1;
    collect("err_misalign", 32'h0, 1'b1);
    collect("err_range", 32'h0, 1'b1);
    collect("err_clean", W0, 1'b0);

    // Loader boundaries: last word written, misaligned and out-of-range writes dropped.
    ld_en = 1'b1;
    ld_addr = 32'h1FC; ld_data = 32'hCAFEF00D; tick();
    ld_addr = 32'h200; ld_data = 32'h12345678; tick();
    ld_addr = 32'h1;   ld_data = 32'hDEADBEEF; tick();
    ld_en = 1'b0;
    issue(32'h1FC);
    collect("ld_last", 32'hCAFEF00D, 1'b0);
    issue(32'h0);
    collect("ld_ignored", W0, 1'b0);

`ifdef I_MEM_PARITY_EN
    dut.par_mem[1] = ~dut.par_mem[1];
    issue(32'h4);
    collect("parity", W1, 1'b1);
    dut.par_mem[1] = ~dut.par_mem[1];
`endif

    // Same-cycle read and load of one word returns the old contents.
    ld_en     = 1'b1;
    ld_addr   = 32'h8;
    ld_data   = 32'hFFFFFFFF;
    req_valid = 1'b1;
    req_addr  = 32'h8;
    chk("rw_ready", 32'(req_ready), 32'd1);
    tick();
    ld_en     = 1'b0;
    req_valid = 1'b0;
    collect("rw_old", W2, 1'b0);
    issue(32'h8);
    collect("rw_new", 32'hFFFFFFFF, 1'b0);

    // Asynchronous reset with the FIFO full and one request in the pipeline.
    rsp_ready = 1'b0;
    issue(32'h0);
    issue(32'h4);
    issue(32'hC);
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    chk("pre_rst_ready", 32'(req_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(rsp_valid), 32'd0);
    chk("async_data", rsp_data, 32'd0);
    chk("async_err", 32'(rsp_err), 32'd0);
    chk("async_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_ready", 32'(req_ready), 32'd1);
    chk("rel_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("no_stale", 32'(rsp_valid), 32'd0);
    end
    issue(32'h4);
    collect("mem_kept", W1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
